tbus_arbiter: RTL
=================

# tbus_arbiter

Round-robin arbiter that shares one tristate bus among N requesters by driving the `EN` inputs of their `tbuf`/`tinv` cells. It guarantees at most one enabled driver at any instant and inserts a programmable dead (turnaround) interval between owners, giving break-before-make on the bus. It optionally preempts an owner that has held the bus too long. It sits between requesting blocks and the tristate drivers of a shared bus net.

## Interface
- `N`, 4: number of requesters; N >= 2
- `MAXHOLD`, 16: maximum consecutive grant cycles before preemption; >= 1
- `TURN`, 1: dead cycles between owners, all enables low; >= 1
- `CLK`  in  1  clock, rising edge
- `RESET`  in  1  reset, asynchronous, active-low
- `REQ`  in  N  request per requester, level; held high while bus is wanted
- `GRANT`  out  N  one-hot-or-zero; wired directly to the `EN` of requester k's tristate driver
- `OWNER`  out  clog2(N)  index of the current owner; valid only while `GRANT` != 0
- `BUSY`  out  1  high in every state except IDLE

## Operation
- States: IDLE, OWN, TURN_AROUND.
- Reset state:
  - state IDLE
  - `GRANT`=0, `OWNER`=0, `BUSY`=0
  - internal RR pointer = N-1, so requester 0 wins first
  - hold counter 0, turn counter 0
- IDLE:
  - On each edge, if any `REQ` is high, pick the winner and go to OWN.
  - No turnaround is needed, because IDLE is only entered after the bus has been released.
- Pick rule: the first set `REQ` bit searching from pointer+1 upward, wrapping N-1 to 0. The pointer then loads the winner index.
- OWN:
  - `GRANT[k]`=1, `OWNER`=k.
  - The hold counter counts granted cycles.
  - Exit to TURN_AROUND on the edge where `REQ[k]` is sampled low.
  - With preemption compiled in, also exit on the edge where hold count == MAXHOLD and any other `REQ` bit is high.
  - If k is the sole requester, no preemption occurs; the counter saturates at MAXHOLD.
- TURN_AROUND:
  - `GRANT`=0 for exactly TURN cycles.
  - On the edge ending the last turn cycle: if any `REQ` is high, pick (pointer = previous owner) and go to OWN; otherwise go to IDLE.
- A preempted requester that keeps `REQ` high stays eligible. It is reconsidered only after the other pending requesters have been served, since the pointer points at it.
- `REQ` is ignored except at arbitration edges and the owner's own bit in OWN. A `REQ` pulse that drops before an arbitration edge is lost.
- Counters:
  - hold counter width clog2(MAXHOLD+1)
  - turn counter width clog2(TURN+1)
  - both reload on state entry and never wrap

## Timing
- All outputs are registered. No combinational path from `REQ` to `GRANT`.
- Grant latency: `REQ` high in IDLE, sampled at edge n, gives `GRANT` high from edge n.
- Release latency: `REQ[k]` sampled low at edge n gives `GRANT[k]` low from edge n.
- Preempted grant width: exactly MAXHOLD cycles.
- Between two owners: exactly TURN cycles with `GRANT`=0.
- Simultaneous events:
  - If the owner drops `REQ` at the same edge the hold limit is hit, the result is a single transition to TURN_AROUND.
  - A new `REQ` arriving at the final turn edge is arbitrated on that edge.
- `RESET` low mid-operation clears `GRANT` asynchronously, releasing the bus without waiting for `CLK`. All state returns to reset values.
- `RESET` deassertion is synchronised externally. The first arbitration occurs on the first edge after release.

## Configuration
- `TBUS_ARB_PREEMPT_EN` defined:
  - the hold counter is present
  - MAXHOLD preemption is active as described above
- Undefined:
  - the hold counter is removed and MAXHOLD is ignored
  - the owner keeps the bus until it drops `REQ`
  - round-robin order applies only at release

## Structure
- Shared package `tbus_pkg`:
  - state encoding constants IDLE / OWN / TURN_AROUND (2 bits)
  - clog2 helper function
- Sub-module `tbus_rr_pick`: combinational N-way rotating priority picker.
  - Inputs: `REQ`, pointer.
  - Outputs: one-hot winner, winner index, any-request flag.
  - Instantiated once.
- The top level holds the FSM, counters, pointer and output flops.

## Test plan
- Reset: hold `RESET` low → `GRANT`=0000, `OWNER`=0, `BUSY`=0. Pull `RESET` low during OWN → `GRANT` is 0 before the next `CLK` edge.
- Single requester (N=4, TURN=1): `REQ`=0010 from edge 0, dropped at edge 5.
  - `GRANT`=0010 for edges 0–4 and `OWNER`=1.
  - `GRANT`=0 from edge 5, `BUSY`=1 for one cycle, then IDLE.
- Round robin with preemption (`TBUS_ARB_PREEMPT_EN`, MAXHOLD=4, TURN=1, `REQ`=1111 constant):
  - grants 0,1,2,3,0 in order, each exactly 4 cycles
  - exactly 1 zero cycle between grants
  - never more than one `GRANT` bit set
- Preemption off, same stimulus: `GRANT`=0001 indefinitely. Dropping `REQ[0]` → 1 dead cycle, then `GRANT`=0010.
- Lone owner (preempt on, MAXHOLD=4): `REQ`=0100 held 20 cycles → `GRANT`=0100 for all 20 cycles, no dead cycles.
- Turnaround arbitration (TURN=2): owner 3 releases while `REQ[1]` rises during the 2nd dead cycle → after exactly 2 zero cycles, `GRANT`=0010.

Source files
------------

// File: rtl/tbus_pkg.sv
// Shared types and helpers for the tristate bus arbiter: FSM state encoding and a
// constant-foldable clog2 used for port and counter widths.
package tbus_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    OWN         = 2'd1,
    TURN_AROUND = 2'd2
  } tbus_state_t;

  // Never returns less than 1 so every derived vector has at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/tbus_rr_pick.sv
// Rotating-priority picker: the first set request found searching upward from ptr+1,
// wrapping from N-1 back to 0. Purely combinational.
module tbus_rr_pick
  import tbus_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  always_comb begin : pick
    int   j;
    logic found;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr) + i) % N;
      if (req[j] && !found) begin
        found      = 1'b1;
        win[j]     = 1'b1;
        win_idx    = IW'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/tbus_arbiter.sv
// Round-robin owner selection for a shared tristate bus with break-before-make dead
// cycles. Define TBUS_ARB_PREEMPT_EN to build in the MAXHOLD preemption logic.
module tbus_arbiter
  import tbus_pkg::*;
#(
  parameter int N       = 4,
  parameter int MAXHOLD = 16,
  parameter int TURN    = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [N-1:0]        REQ,
  output logic [N-1:0]        GRANT,
  output logic [clog2(N)-1:0] OWNER,
  output logic                BUSY
);

  localparam int IW = clog2(N);
  localparam int TW = clog2(TURN + 1);

  // Handshake: REQ[k] is a level held high for as long as requester k wants the bus;
  // GRANT[k] high means its driver is enabled; GRANT[k] falls on the edge REQ[k] is seen low.

  tbus_state_t   state, state_nx;
  logic [IW-1:0] ptr, ptr_nx;
  logic [N-1:0]  grant_nx;
  logic [IW-1:0] owner_nx;
  logic [TW-1:0] turn_cnt, turn_nx;
  logic [N-1:0]  pick_win;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          owner_req;
  logic          hold_exit;

  tbus_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req     (REQ),
    .ptr     (ptr),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign owner_req = REQ[OWNER];

`ifdef TBUS_ARB_PREEMPT_EN
  localparam int HW = clog2(MAXHOLD + 1);
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [N-1:0]  others;

  assign others    = REQ & ~GRANT;
  assign hold_exit = (hold_cnt == HW'(MAXHOLD)) && (|others);

  // Loads 1 on the entry edge so the count equals granted cycles; saturates for a lone owner.
  always_comb begin
    hold_nx = hold_cnt;
    if (state_nx == OWN && state != OWN)
      hold_nx = HW'(1);
    else if (state == OWN && hold_cnt != HW'(MAXHOLD))
      hold_nx = hold_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) hold_cnt <= '0;
    else        hold_cnt <= hold_nx;
  end
`else
  // MAXHOLD >= 1, so this is constant low: the owner keeps the bus until it releases.
  assign hold_exit = (MAXHOLD < 1);
`endif

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    grant_nx = GRANT;
    owner_nx = OWNER;
    turn_nx  = turn_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_nx = OWN;
          ptr_nx   = pick_idx;
          grant_nx = pick_win;
          owner_nx = pick_idx;
        end
      end
      OWN: begin
        if (!owner_req || hold_exit) begin
          state_nx = TURN_AROUND;
          grant_nx = '0;
          turn_nx  = TW'(1);
        end
      end
      TURN_AROUND: begin
        if (turn_cnt == TW'(TURN)) begin
          if (pick_any) begin
            state_nx = OWN;
            ptr_nx   = pick_idx;
            grant_nx = pick_win;
            owner_nx = pick_idx;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          turn_nx = turn_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  // Asynchronous reset drops every enable immediately, releasing the bus without a clock.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      ptr      <= IW'(N - 1);
      GRANT    <= '0;
      OWNER    <= '0;
      BUSY     <= 1'b0;
      turn_cnt <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      GRANT    <= grant_nx;
      OWNER    <= owner_nx;
      BUSY     <= (state_nx != IDLE);
      turn_cnt <= turn_nx;
    end
  end

endmodule
